// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between NREQ requesters.
//
// Requests are served in round-robin order. The winner's word is
// captured at grant time and presented to the SPI master on din, with
// newd held high until the master pulls cs_in low. When cs_in returns
// high, the requester receives a one-cycle ack. A transfer that does
// not complete within TIMEOUT cycles of the grant is abandoned with a
// one-cycle err pulse and no ack.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req       per-requester level request, held until ack or err
//   req_data  requester i's word in bits [i*DW +: DW]
//   cs_in     SPI master chip select, low while a transfer runs
//   newd      new-data strobe to the SPI master
//   din       word to the SPI master, zero when idle
//   gnt       one-hot grant, zero when idle
//   ack       one-cycle completion pulse to the granted requester
//   err       one-cycle timeout pulse
//   busy      high whenever the arbiter is not idle
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              cs_in,
  output logic              newd,
  output logic [DW-1:0]     din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE   = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   next_ptr;
  logic            found;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   din_reg;
  logic            timeout;
  logic            do_grant;
  logic            do_done;
  logic            do_abort;

  // Round-robin search: scan from ptr upward, wrapping modulo NREQ, and
  // take the first active request. ptr always names the requester just
  // after the last one served, so a requester that keeps req high is
  // only revisited after everyone else has had a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign next_ptr = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign timeout  = (timer == TLAST);
  assign din      = (state == IDLE) ? '0 : din_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. In WAIT a completing cs_in beats a
  // simultaneous timeout so a finished transfer is always acknowledged.
  // cs_in is only looked at once a grant exists, so a master still
  // low from earlier activity cannot trigger anything from IDLE.
  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    newd       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          do_grant   = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        newd = 1'b1;
        if (timeout) begin
          do_abort   = 1'b1;
          next_state = IDLE;
        end else if (!cs_in) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cs_in) begin
          do_done    = 1'b1;
          next_state = IDLE;
        end else if (timeout) begin
          do_abort   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant, data capture, timer and completion bookkeeping. The word is
  // latched at grant so later req_data changes do not disturb the
  // transfer; ack is taken from gnt so it always hits the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      winner  <= '0;
      timer   <= '0;
      din_reg <= '0;
      gnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      if (state != IDLE) begin
        timer <= timer + 1'b1;
      end
      if (do_grant) begin
        winner  <= pick;
        gnt     <= ONE << pick;
        din_reg <= req_data[int'(pick)*DW +: DW];
        timer   <= '0;
      end
      if (do_done) begin
        ack <= gnt;
        gnt <= '0;
        ptr <= next_ptr;
      end
      if (do_abort) begin
        err <= 1'b1;
        gnt <= '0;
        ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed self-checking bench for spi_arbiter
// (NREQ=4, DW=12, TIMEOUT=16). The SPI master is modelled by driving
// cs_in directly from the stimulus sequence.
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int TO   = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic              cs_in;
  logic              newd;
  logic [DW-1:0]     din;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;

  int checkCount = 0;
  int passCount  = 0;

  spi_arbiter #(
    .NREQ(NREQ),
    .DW(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .cs_in(cs_in),
    .newd(newd),
    .din(din),
    .gnt(gnt),
    .ack(ack),
    .err(err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] rq, input logic cs);
    rst   = r;
    req   = rq;
    cs_in = cs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int idx, input logic [DW-1:0] val);
    req_data[idx*DW +: DW] = val;
  endtask

  // Expects IDLE with a request pending and cs_in high; runs one grant,
  // cs_in low/high handshake, and checks the ack pulse.
  task automatic runTransfer(input int idx, input logic [DW-1:0] word);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    tick();
    checkOutput("grant gnt", 32'(gnt), 32'(oh));
    checkOutput("grant newd", 32'(newd), 32'd1);
    checkOutput("grant din", 32'(din), 32'(word));
    checkOutput("grant ack", 32'(ack), 32'd0);
    cs_in = 1'b0;
    tick();
    checkOutput("wait newd", 32'(newd), 32'd0);
    checkOutput("wait din", 32'(din), 32'(word));
    cs_in = 1'b1;
    tick();
    checkOutput("done ack", 32'(ack), 32'(oh));
    checkOutput("done gnt", 32'(gnt), 32'd0);
    checkOutput("done busy", 32'(busy), 32'd0);
    checkOutput("done err", 32'(err), 32'd0);
  endtask

  // Continuous invariants: gnt and ack never multi-hot, ack never
  // together with err.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("gnt onehot0", 32'($onehot0(gnt)), 32'd1);
      checkOutput("ack onehot0", 32'($onehot0(ack)), 32'd1);
      checkOutput("ack with err", 32'((ack != '0) && err), 32'd0);
    end
  end

  initial begin
    req_data = '0;
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    tick();
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset newd", 32'(newd), 32'd0);
    checkOutput("reset din", 32'(din), 32'd0);
    checkOutput("reset ack", 32'(ack), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);

    $display("[TB] single request");
    setData(2, 12'hA5C);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    tick();
    checkOutput("single gnt", 32'(gnt), 32'b0100);
    checkOutput("single busy", 32'(busy), 32'd1);
    tick();
    checkOutput("single newd held", 32'(newd), 32'd1);
    cs_in = 1'b0;
    tick();
    checkOutput("single newd drop", 32'(newd), 32'd0);
    checkOutput("single din", 32'(din), 32'hA5C);
    cs_in = 1'b1;
    tick();
    checkOutput("single ack", 32'(ack), 32'b0100);
    checkOutput("single busy idle", 32'(busy), 32'd0);
    checkOutput("single din idle", 32'(din), 32'd0);
    req = 4'b0000;
    tick();
    checkOutput("single ack pulse", 32'(ack), 32'd0);

    $display("[TB] round-robin pointer");
    setData(0, 12'h301);
    req = 4'b0101;
    runTransfer(0, 12'h301);
    req = 4'b0100;
    runTransfer(2, 12'hA5C);
    req = 4'b0000;
    tick();

    $display("[TB] contention");
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    setData(0, 12'h0F1);
    setData(1, 12'h3C2);
    setData(2, 12'h5A3);
    setData(3, 12'hFE4);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    runTransfer(0, 12'h0F1);
    runTransfer(1, 12'h3C2);
    runTransfer(2, 12'h5A3);
    runTransfer(3, 12'hFE4);
    runTransfer(0, 12'h0F1);
    req = 4'b0000;
    tick();

    $display("[TB] timeout");
    setData(1, 12'h777);
    setData(2, 12'h888);
    req = 4'b0110;
    tick();
    checkOutput("to gnt", 32'(gnt), 32'b0010);
    for (int i = 0; i < TO - 1; i++) tick();
    checkOutput("to early err", 32'(err), 32'd0);
    checkOutput("to early gnt", 32'(gnt), 32'b0010);
    checkOutput("to early newd", 32'(newd), 32'd1);
    tick();
    checkOutput("to err", 32'(err), 32'd1);
    checkOutput("to gnt clear", 32'(gnt), 32'd0);
    checkOutput("to no ack", 32'(ack), 32'd0);
    checkOutput("to newd", 32'(newd), 32'd0);
    req = 4'b0100;
    tick();
    checkOutput("to next gnt", 32'(gnt), 32'b0100);
    checkOutput("to err pulse", 32'(err), 32'd0);
    checkOutput("to next din", 32'(din), 32'h888);

    $display("[TB] data stability");
    cs_in = 1'b0;
    tick();
    setData(2, 12'hBAD);
    req = 4'b0000;
    tick();
    checkOutput("stable din", 32'(din), 32'h888);
    checkOutput("stable gnt", 32'(gnt), 32'b0100);
    cs_in = 1'b1;
    tick();
    checkOutput("stable ack", 32'(ack), 32'b0100);
    tick();

    $display("[TB] completion beats timeout");
    setData(3, 12'h123);
    req = 4'b1000;
    tick();
    checkOutput("prio gnt", 32'(gnt), 32'b1000);
    cs_in = 1'b0;
    tick();
    for (int i = 0; i < TO - 2; i++) tick();
    checkOutput("prio busy", 32'(busy), 32'd1);
    cs_in = 1'b1;
    tick();
    checkOutput("prio ack", 32'(ack), 32'b1000);
    checkOutput("prio err", 32'(err), 32'd0);
    req = 4'b0000;
    tick();
    checkOutput("prio late err", 32'(err), 32'd0);

    $display("[TB] cs_in low while idle");
    cs_in = 1'b0;
    tick();
    checkOutput("idle cs busy", 32'(busy), 32'd0);
    checkOutput("idle cs newd", 32'(newd), 32'd0);
    cs_in = 1'b1;
    tick();

    $display("[TB] reset mid-transfer");
    setData(1, 12'h456);
    req = 4'b0010;
    tick();
    checkOutput("rst gnt", 32'(gnt), 32'b0010);
    cs_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst mid gnt", 32'(gnt), 32'd0);
    checkOutput("rst mid busy", 32'(busy), 32'd0);
    checkOutput("rst mid newd", 32'(newd), 32'd0);
    checkOutput("rst mid din", 32'(din), 32'd0);
    checkOutput("rst mid ack", 32'(ack), 32'd0);
    checkOutput("rst mid err", 32'(err), 32'd0);
    setData(3, 12'h789);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    runTransfer(3, 12'h789);
    req = 4'b0000;
    tick();
    checkOutput("end ack", 32'(ack), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Parameters
REQ-001 NREQ, 4, number of requesters sharing one SPI master (2..8).
REQ-002 DW, 12, SPI word width in bits.
REQ-003 TIMEOUT, 1024, maximum clk cycles from grant to transfer completion before abort.

Interface
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester transfer request; level, held until ack or err.
REQ-007 req_data  input  NREQ*DW  requester i's word in bits [i*DW +: DW].
REQ-008 cs_in  input  1  chip select from the SPI master; low means transfer in progress.
REQ-009 newd  output  1  new-data strobe to the SPI master.
REQ-010 din  output  DW  word to the SPI master.
REQ-011 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-012 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-013 err  output  1  one-cycle timeout pulse.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, LAUNCH and WAIT.
REQ-016 IDLE with req != 0: the winner is chosen by round-robin, starting the search at index ptr and wrapping modulo NREQ.
  - On the next edge: gnt = onehot(winner), din_reg = winner's req_data, timer = 0, state = LAUNCH.
REQ-017 LAUNCH: newd = 1 and din = din_reg.
  - When cs_in is sampled 0: newd = 0 on the next edge and state = WAIT.
  - newd is held high for as many cycles as the SPI master needs to accept the word (it samples on its slow sclk).
REQ-018 WAIT: newd = 0, waiting for cs_in to return to 1.
  - On the edge where cs_in is sampled 1: ack[winner] = 1 for exactly one cycle, gnt = 0, ptr = (winner+1) mod NREQ, state = IDLE.
REQ-019 Latency: the earliest grant is 1 cycle after req is seen in IDLE. The earliest next grant is 1 cycle after the ack cycle; IDLE always lasts at least one cycle.
REQ-020 din SHALL hold din_reg throughout LAUNCH and WAIT.
  - Changes to req_data after the grant are ignored.
  - din = 0 in IDLE.
REQ-021 Deasserting req while granted SHALL NOT abort the transfer; ack is still issued.
REQ-022 A requester holding req after its ack SHALL be re-granted only after every other pending requester has been served once.
REQ-023 timer increments every cycle in LAUNCH and WAIT. When timer reaches TIMEOUT-1:
  - err = 1 for one cycle;
  - newd = 0, gnt = 0, no ack;
  - ptr = (winner+1) mod NREQ, state = IDLE.
REQ-024 If timeout and cs_in completion occur on the same edge, completion SHALL take priority: ack is issued and err is not.
REQ-025 cs_in already low in IDLE SHALL be ignored; only cs_in observed in LAUNCH and WAIT is acted on.
REQ-026 ack and err SHALL never be asserted in the same cycle. At most one ack bit is high at any time.
REQ-027 gnt SHALL be one-hot or zero at all times, and SHALL be nonzero only in LAUNCH and WAIT.

Reset
REQ-028 With rst high at an edge, the block SHALL enter IDLE with:
  - ptr = 0, timer = 0, din_reg = 0;
  - newd = 0, din = 0, gnt = 0, ack = 0, err = 0, busy = 0.
REQ-029 Reset mid-transfer SHALL abort without ack or err.
  - The block does not wait for cs_in; the SPI master is reset by the same rst.
REQ-030 The first grant after reset SHALL go to the lowest-indexed active requester.

Verification
REQ-031 Single request: req = 4'b0100 with data 0xA5C.
  - Expect gnt = 4'b0100 after 1 cycle, newd high until cs_in falls, din = 0xA5C.
  - Expect ack[2] one cycle after cs_in rises, then busy = 0.
REQ-032 Contention: req = 4'b1111 held high after reset.
  - Expect grant order 0, 1, 2, 3, 0, each word delivered intact, gnt never multi-hot.
REQ-033 Round-robin pointer: after serving requester 2, assert req = 4'b0101.
  - Expect requester 0 served before requester 2 again.
REQ-034 Timeout: grant with cs_in held 1, TIMEOUT = 16.
  - Expect err pulse exactly 16 cycles after entering LAUNCH, gnt = 0, no ack, then the next requester is granted.
REQ-035 Reset mid-transfer: assert rst during WAIT.
  - Expect all outputs 0 on the next cycle and no ack.
  - After rst drops, req = 4'b1000 is granted normally.
REQ-036 Data stability: change req_data and drop req during WAIT.
  - Expect din unchanged and ack still issued.
